// File: rtl/watchdog_timer.sv
// Parametrised watchdog timer with programmable timeout, early warning and a
// multi-cycle reset request. Define WDT_WINDOW_EN to reject kicks that arrive too early.
module watchdog_timer #(
  parameter int CNT_W   = 16,
  parameter int RST_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] warn_val,
  input  logic [CNT_W-1:0] window_val,
  output logic [CNT_W-1:0] count,
  output logic             warning,
  output logic             timeout,
  output logic             rst_req,
  output logic             window_err
);

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] ld_s, ld_d;
  logic [CNT_W-1:0] wn_s, wn_d;
  logic [RW-1:0]    rst_left, rst_left_d;
  logic             rst_req_d;
  logic             window_err_d;
  logic             early_kick;

`ifdef WDT_WINDOW_EN
  logic [CNT_W-1:0] wd_s, wd_d;
  assign early_kick = (state == RUN) && restart && (wd_s != '0) && (count < wd_s);
`else
  logic unused_window;
  assign unused_window = ^window_val;
  assign early_kick    = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no latch is inferred
  // for paths that do not assign it.
  always_comb begin
    state_d      = state;
    count_d      = count;
    ld_d         = ld_s;
    wn_d         = wn_s;
`ifdef WDT_WINDOW_EN
    wd_d         = wd_s;
`endif
    rst_left_d   = rst_left;
    rst_req_d    = 1'b0;
    window_err_d = 1'b0;

    if (!enable) begin
      state_d    = IDLE;
      count_d    = '0;
      rst_left_d = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = RUN;
          count_d = '0;
          ld_d    = load_val;
          wn_d    = warn_val;
`ifdef WDT_WINDOW_EN
          wd_d    = window_val;
`endif
        end
        RUN: begin
          if (early_kick) begin
            state_d      = EXPIRED;
            window_err_d = 1'b1;
            rst_req_d    = 1'b1;
            rst_left_d   = RW'(RST_CYC - 1);
          end else if (restart) begin
            count_d = '0;
            ld_d    = load_val;
            wn_d    = warn_val;
`ifdef WDT_WINDOW_EN
            wd_d    = window_val;
`endif
          end else if (count == ld_s) begin
            state_d    = EXPIRED;
            rst_req_d  = 1'b1;
            rst_left_d = RW'(RST_CYC - 1);
          end else begin
            count_d = count + 1'b1;
          end
        end
        EXPIRED: begin
          if (restart) begin
            state_d    = RUN;
            count_d    = '0;
            rst_left_d = '0;
            ld_d       = load_val;
            wn_d       = warn_val;
`ifdef WDT_WINDOW_EN
            wd_d       = window_val;
`endif
          end else if (rst_req && (rst_left != '0)) begin
            // Pulse length is RST_CYC: one cycle on entry plus RST_CYC-1 more.
            rst_req_d  = 1'b1;
            rst_left_d = rst_left - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      ld_s       <= '0;
      wn_s       <= '0;
`ifdef WDT_WINDOW_EN
      wd_s       <= '0;
`endif
      rst_left   <= '0;
      rst_req    <= 1'b0;
      window_err <= 1'b0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      ld_s       <= ld_d;
      wn_s       <= wn_d;
`ifdef WDT_WINDOW_EN
      wd_s       <= wd_d;
`endif
      rst_left   <= rst_left_d;
      rst_req    <= rst_req_d;
      window_err <= window_err_d;
    end
  end

  // A warning threshold at or above the timeout threshold never fires.
  assign warning = (state == RUN) && (wn_s < ld_s) && (count >= wn_s);
  assign timeout = (state == EXPIRED);

endmodule

// File: tb/tb_watchdog_timer.sv
// Directed bench for watchdog_timer (CNT_W=8, RST_CYC=4): a vector table for
// basic expiry plus hand-written sequences for kicks, resets and thresholds.
module tb_watchdog_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, restart;
  logic [7:0] load_val, warn_val, window_val;
  logic [7:0] count;
  logic       warning, timeout, rst_req, window_err;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       en, rs;
    logic [7:0] ld, wn, wd;
    logic [7:0] cnt;
    logic       warn, to, rr, we;
  } vec_t;

  vec_t vecs[$];

  watchdog_timer #(.CNT_W(8), .RST_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .load_val(load_val), .warn_val(warn_val), .window_val(window_val),
    .count(count), .warning(warning), .timeout(timeout),
    .rst_req(rst_req), .window_err(window_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_out(input string tag, input logic [7:0] c, input logic w,
                           input logic t, input logic r, input logic e);
    check({tag, ".count"},      32'(count),      32'(c));
    check({tag, ".warning"},    32'(warning),    32'(w));
    check({tag, ".timeout"},    32'(timeout),    32'(t));
    check({tag, ".rst_req"},    32'(rst_req),    32'(r));
    check({tag, ".window_err"}, 32'(window_err), 32'(e));
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after posedge.
  task automatic step(input logic en, input logic rs, input logic [7:0] ld,
                      input logic [7:0] wn, input logic [7:0] wd);
    enable = en; restart = rs; load_val = ld; warn_val = wn; window_val = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; restart = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(logic en, logic rs, logic [7:0] ld, logic [7:0] wn,
                              logic [7:0] wd, logic [7:0] cnt, logic warn,
                              logic to, logic rr, logic we);
    vec_t v;
    v.en = en; v.rs = rs; v.ld = ld; v.wn = wn; v.wd = wd;
    v.cnt = cnt; v.warn = warn; v.to = to; v.rr = rr; v.we = we;
    return v;
  endfunction

  initial begin
    // Basic expiry: load 10, warn 7, no kicks; one row per clock edge from E0.
    vecs.push_back(mk(1, 0, 10, 7, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0,  2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0,  3, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0,  4, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0,  5, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0,  6, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0,  7, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0,  8, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0,  9, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0, 10, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0, 10, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0, 10, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0, 10, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0, 10, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0, 10, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 10, 7, 0, 10, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 10, 7, 0,  0, 0, 0, 0, 0));

    enable = 1'b0; restart = 1'b0; load_val = '0; warn_val = '0; window_val = '0;
    rst_n = 1'b0;
    #12;
    check_out("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].rs, vecs[i].ld, vecs[i].wn, vecs[i].wd);
      check_out($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].warn, vecs[i].to,
                vecs[i].rr, vecs[i].we);
    end

    // Kick exactly at count==ld_s wins; the new threshold 5 is captured at the kick.
    do_reset();
    step(1, 0, 10, 7, 0);
    repeat (10) step(1, 0, 10, 7, 0);
    check_out("bound.pre", 10, 1, 0, 0, 0);
    step(1, 1, 5, 7, 0);
    check_out("bound.kick", 0, 0, 0, 0, 0);
    repeat (5) step(1, 0, 10, 7, 0);
    check_out("bound.c5", 5, 0, 0, 0, 0);
    step(1, 0, 10, 7, 0);
    check_out("bound.exp", 5, 0, 1, 1, 0);

    // Kick during the 2nd rst_req cycle aborts it; then enable drop returns to IDLE.
    do_reset();
    step(1, 0, 10, 7, 0);
    repeat (11) step(1, 0, 10, 7, 0);
    check_out("rec.exp1", 10, 0, 1, 1, 0);
    step(1, 0, 10, 7, 0);
    check_out("rec.exp2", 10, 0, 1, 1, 0);
    step(1, 1, 10, 7, 0);
    check_out("rec.kick", 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 10, 7, 0);
    check_out("rec.c3", 3, 0, 0, 0, 0);
    step(0, 0, 10, 7, 0);
    check_out("rec.idle", 0, 0, 0, 0, 0);

    // Asynchronous reset between edges at count 6.
    do_reset();
    step(1, 0, 10, 2, 0);
    repeat (6) step(1, 0, 10, 2, 0);
    check_out("arst.pre", 6, 1, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("arst.low", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 10, 2, 0);
    check_out("arst.e0", 0, 0, 0, 0, 0);
    step(1, 0, 10, 2, 0);
    check_out("arst.e1", 1, 0, 0, 0, 0);

    // load_val 0: a single RUN cycle before expiry.
    do_reset();
    step(1, 0, 0, 5, 0);
    check_out("ld0.run", 0, 0, 0, 0, 0);
    step(1, 0, 0, 5, 0);
    check_out("ld0.exp", 0, 0, 1, 1, 0);

    // warn_val 0 with load_val 3: warning across the whole of RUN.
    do_reset();
    step(1, 0, 3, 0, 0);
    check_out("wn0.c0", 0, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 3, 0, 0);
      check_out($sformatf("wn0.c%0d", i), 8'(i), 1, 0, 0, 0);
    end
    step(1, 0, 3, 0, 0);
    check_out("wn0.exp", 3, 0, 1, 1, 0);

    // warn_val equal to load_val: warning never fires.
    do_reset();
    step(1, 0, 3, 3, 0);
    repeat (3) step(1, 0, 3, 3, 0);
    check_out("wneq.c3", 3, 0, 0, 0, 0);

    // Early kick at count 2 with window 4.
    do_reset();
    step(1, 0, 10, 7, 4);
    repeat (2) step(1, 0, 10, 7, 4);
    check_out("win.c2", 2, 0, 0, 0, 0);
    step(1, 1, 10, 7, 4);
`ifdef WDT_WINDOW_EN
    check_out("win.early", 2, 0, 1, 1, 1);
    step(1, 0, 10, 7, 4);
    check_out("win.after", 2, 0, 1, 1, 0);
`else
    check_out("win.early", 0, 0, 0, 0, 0);
    step(1, 0, 10, 7, 4);
    check_out("win.after", 1, 0, 0, 0, 0);
`endif

    // Kick at count 4 is inside the window and accepted in either build.
    do_reset();
    step(1, 0, 10, 7, 4);
    repeat (4) step(1, 0, 10, 7, 4);
    check_out("win.c4", 4, 0, 0, 0, 0);
    step(1, 1, 10, 7, 4);
    check_out("win.ok", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/watchdog_timer.md
# watchdog_timer

Parametrised watchdog timer, successor to the fixed 4-bit `Watchdog` block. It generalises the counter width and makes the timeout threshold programmable. It adds an early-warning output, a multi-cycle system reset request and, optionally, windowed servicing, in which a restart that arrives too early is a fault. It sits beside the system controller: software services it through `restart`, and `rst_req` drives the chip reset generator.

## Interface
- `CNT_W`, default 16: counter and threshold width in bits, valid range 4..32.
- `RST_CYC`, default 4: length of `rst_req` in cycles, minimum 1.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `enable` input 1: watchdog armed while high.
- `restart` input 1: service pulse (kick); each cycle it is high counts as one kick.
- `load_val` input CNT_W: timeout threshold.
- `warn_val` input CNT_W: early-warning threshold.
- `window_val` input CNT_W: earliest legal kick count (used only with `WDT_WINDOW_EN`).
- `count` output CNT_W: current counter value.
- `warning` output 1: early warning.
- `timeout` output 1: watchdog expired; sticky.
- `rst_req` output 1: system reset request pulse.
- `window_err` output 1: one-cycle pulse on an early kick.

## Operation
- Shadow registers `ld_s`, `wn_s` and `wd_s` capture `load_val`, `warn_val` and `window_val` on the IDLE->RUN transition and on every accepted kick. The thresholds are not read live at any other time.
- States and transitions:
  - IDLE: `count`=0 and all outputs are low. Moves to RUN when `enable`=1.
  - RUN: `count` increments by 1 per cycle.
    - A kick sets `count` to 0 and reloads the shadows.
    - When `count`==`ld_s` and there is no kick, the next state is EXPIRED.
  - EXPIRED: `timeout`=1 and `count` is held.
    - `rst_req`=1 for the first `RST_CYC` cycles of EXPIRED, then 0.
    - A kick returns the block to RUN with `count`=0 and reloads the shadows.
- Priority, highest first: `rst_n` low, then `enable`=0, then kick, then the expiry compare.
  - `enable`=0 in any state forces IDLE on the next edge. All outputs clear, and any `rst_req` pulse is aborted.
  - A kick in the same cycle as `count`==`ld_s` wins: the counter reloads and no timeout occurs.
  - A kick during the `rst_req` pulse aborts the pulse, so `rst_req`=0 on the next edge.
- `warning` = (state==RUN) && (`count` >= `wn_s`). It is decoded from registers only. If `wn_s` >= `ld_s`, `warning` never asserts.
- `ld_s`=0 is a legal threshold: RUN lasts exactly one cycle before EXPIRED.
- The counter never wraps. It stops at `ld_s`, which is at most 2^CNT_W-1.
- All outputs are driven from registers or from decodes of registers; no input reaches an output combinationally.
- Values of every register and output in reset: 0, state IDLE, shadows 0.

## Timing
- `enable` sampled high at edge E0: state=RUN and `count`=0 after E0. After edge E0+n, `count`=n.
- `timeout` rises after edge E0+`ld_s`+1, i.e. `ld_s`+1 cycles of RUN without a kick.
- `rst_req` rises at the same edge as `timeout` and stays high for `RST_CYC` cycles.
- A kick sampled at edge K gives `count`=0 after K. Counting then resumes exactly as from E0.
- `window_err` is a single-cycle pulse, asserted the edge after the early kick is sampled.
- Asserting `rst_n` mid-operation clears everything immediately, without waiting for `clk`.

## Configuration
- `WDT_WINDOW_EN` defined:
  - A kick in RUN with `count` < `wd_s` is a window violation.
  - On a violation, `window_err` pulses for one cycle and the next state is EXPIRED, with `timeout`=1 and the `rst_req` pulse starting on that edge.
  - A kick in EXPIRED is always accepted.
  - `wd_s`=0 disables the window check.
- `WDT_WINDOW_EN` undefined:
  - `window_val` is ignored and `window_err` is tied to 0.
  - Every kick is accepted.

## Test plan
- Basic expiry: CNT_W=8, `load_val`=10, `warn_val`=7, `enable` raised, no kicks.
  - `warning` is high from `count`=7 to `count`=10.
  - `timeout` rises 11 cycles after entering RUN.
  - `rst_req` is high for exactly 4 cycles; `count` holds at 10.
- Kick at the expiry boundary: kick in the cycle where `count`=10.
  - `count` goes to 0 and `timeout` never asserts.
  - A changed `load_val`=5 applied at the kick takes effect: expiry follows 6 cycles later.
- Recovery and abort: kick during the 2nd `rst_req` cycle, then `enable` dropped in a later RUN.
  - The kick gives `rst_req`=0 and `timeout`=0 on the next edge, and the block resumes RUN from 0.
  - Dropping `enable` gives IDLE with all outputs 0.
- Async reset: pull `rst_n` low mid-count (`count`=6) between clock edges.
  - `count` and all outputs go to 0 immediately.
  - `enable` held high after release gives RUN from 0.
- Edge thresholds: `load_val`=0.
  - `timeout` rises after 1 RUN cycle.
  - `warn_val`=0 with `load_val`=3 gives `warning` high for all of RUN.
- Window mode (`WDT_WINDOW_EN`): `window_val`=4, `load_val`=10.
  - A kick at `count`=2 gives a 1-cycle `window_err`, and `timeout`=1 on the same edge.
  - A kick at `count`=4 is accepted normally.
  - Without the macro, the same early kick is accepted and `window_err`=0.
